// File: rtl/conv_mac_pipe.sv
// Pipelined multiply-accumulate for convolution sums: NUM_STAGE product stages
// feed an accumulator that emits one framed sum per 'last' term.
module conv_mac_pipe #(
  parameter int ID          = 1,
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 16,
  parameter int DOUT_WIDTH  = 32,
  parameter int NUM_STAGE   = 3,
  parameter int DIN1_SIGNED = 0,
  parameter int SATURATE    = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  first,
  input  logic                  last,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  overflow
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  logic signed [DIN1_WIDTH:0] din1_ext;
  logic signed [PW:0]         prod_full;
  logic [PW-1:0]              prod_trim;

  // The exact product always fits in PW signed bits, so the top bit is redundant.
  assign din1_ext  = (DIN1_SIGNED != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};
  assign prod_full = $signed(din0) * din1_ext;
  assign prod_trim = prod_full[PW-1:0];

  logic [PW-1:0] prod_reg  [NUM_STAGE];
  logic          valid_reg [NUM_STAGE];
  logic          first_reg [NUM_STAGE];
  logic          last_reg  [NUM_STAGE];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
      logic [PW-1:0] prod_d;
      logic          valid_d;
      logic          first_d;
      logic          last_d;

      if (gi == 0) begin : g_in
        assign prod_d  = prod_trim;
        assign valid_d = in_valid;
        assign first_d = first;
        assign last_d  = last;
      end else begin : g_chain
        assign prod_d  = prod_reg[gi-1];
        assign valid_d = valid_reg[gi-1];
        assign first_d = first_reg[gi-1];
        assign last_d  = last_reg[gi-1];
      end

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          prod_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
          first_reg[gi] <= 1'b0;
          last_reg[gi]  <= 1'b0;
        end else if (ce) begin
          prod_reg[gi]  <= prod_d;
          valid_reg[gi] <= valid_d;
          first_reg[gi] <= first_d;
          last_reg[gi]  <= last_d;
        end
      end
    end
  endgenerate

  logic [PW-1:0]         em_prod;
  logic                  em_valid;
  logic                  em_first;
  logic                  em_last;
  logic [DOUT_WIDTH-1:0] prod_ext;
  logic [DOUT_WIDTH:0]   sum_wide;
  logic                  add_ovf;
  logic [DOUT_WIDTH-1:0] sat_val;
  logic [DOUT_WIDTH-1:0] add_res;
  logic [DOUT_WIDTH-1:0] acc_next;
  logic                  ovf_next;

  logic [DOUT_WIDTH-1:0] acc_reg;
  logic                  acc_ovf_reg;
  logic [DOUT_WIDTH-1:0] dout_reg;
  logic                  ovf_out_reg;
  logic                  out_valid_reg;

  assign em_prod  = prod_reg[NUM_STAGE-1];
  assign em_valid = valid_reg[NUM_STAGE-1];
  assign em_first = first_reg[NUM_STAGE-1];
  assign em_last  = last_reg[NUM_STAGE-1];

  assign prod_ext = DOUT_WIDTH'($signed(em_prod));

  // One guard bit: overflow whenever the guard and sign bits disagree.
  assign sum_wide = {acc_reg[DOUT_WIDTH-1], acc_reg} + {prod_ext[DOUT_WIDTH-1], prod_ext};
  assign add_ovf  = sum_wide[DOUT_WIDTH] ^ sum_wide[DOUT_WIDTH-1];
  assign sat_val  = sum_wide[DOUT_WIDTH] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  assign add_res  = (add_ovf && (SATURATE != 0)) ? sat_val : sum_wide[DOUT_WIDTH-1:0];

  assign acc_next = em_first ? prod_ext : add_res;
  assign ovf_next = em_first ? 1'b0 : (acc_ovf_reg | add_ovf);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_reg     <= '0;
      acc_ovf_reg <= 1'b0;
      dout_reg    <= '0;
      ovf_out_reg <= 1'b0;
    end else if (ce && em_valid) begin
      acc_reg     <= acc_next;
      acc_ovf_reg <= ovf_next;
      if (em_last) begin
        dout_reg    <= acc_next;
        ovf_out_reg <= ovf_next;
      end
    end
  end

  // Cleared on ce=0 edges so a stalled pulse can never reappear as a duplicate.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= ce & em_valid & em_last;
    end
  end

  assign out_valid = out_valid_reg & ce;
  assign dout      = dout_reg;
  assign overflow  = ovf_out_reg;

  logic unused_bits;
  assign unused_bits = prod_full[PW] ^ (ID != 0);

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Drives four differently-parameterised conv_mac_pipe instances with one shared
// stimulus stream and checks each against a scoreboard of modelled sums.
module tb_conv_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    = 1'b1;
  logic        ce       = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] din0     = '0;
  logic [15:0] din1     = '0;
  logic        first    = 1'b0;
  logic        last     = 1'b0;

  logic        ov_w   [4];
  logic [31:0] dout_w [4];
  logic        ovf_w  [4];

  // cfg0 defaults, cfg1 wrapping, cfg2 signed din1, cfg3 single stage
  conv_mac_pipe #(.ID(0)) u_dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .out_valid(ov_w[0]), .dout(dout_w[0]), .overflow(ovf_w[0]));
  conv_mac_pipe #(.ID(1), .SATURATE(0)) u_dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .out_valid(ov_w[1]), .dout(dout_w[1]), .overflow(ovf_w[1]));
  conv_mac_pipe #(.ID(2), .DIN1_SIGNED(1)) u_dut2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .out_valid(ov_w[2]), .dout(dout_w[2]), .overflow(ovf_w[2]));
  conv_mac_pipe #(.ID(3), .NUM_STAGE(1)) u_dut3 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .out_valid(ov_w[3]), .dout(dout_w[3]), .overflow(ovf_w[3]));

  typedef struct {
    logic [31:0] dout;
    logic        ovf;
    int          t;
  } exp_t;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  int     ns_p  [4] = '{3, 3, 3, 1};
  int     sat_p [4] = '{1, 0, 1, 1};
  int     sgn_p [4] = '{0, 0, 1, 0};

  exp_t   sb [4][$];
  longint acc_m [4];
  bit     ovf_m [4];
  int     pulse_cyc [4];

  int n_assert = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int cyc      = 0;
  int c_last   = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ce) en_cnt <= en_cnt + 1;
  end

  function automatic longint mprod(input int i, input logic [15:0] a, input logic [15:0] b);
    longint pa;
    longint pb;
    pa = longint'($signed(a));
    pb = (sgn_p[i] != 0) ? longint'($signed(b)) : longint'(b);
    return pa * pb;
  endfunction

  task automatic model_term(input logic [15:0] a, input logic [15:0] b, input logic f, input logic l);
    longint s;
    exp_t   e;
    for (int i = 0; i < 4; i++) begin
      s = mprod(i, a, b);
      if (f) begin
        acc_m[i] = s;
        ovf_m[i] = 1'b0;
      end else begin
        s = acc_m[i] + s;
        if (s > MAXV || s < MINV) begin
          ovf_m[i] = 1'b1;
          if (sat_p[i] != 0) s = (s > 0) ? MAXV : MINV;
          else               s = longint'($signed(s[31:0]));
        end
        acc_m[i] = s;
      end
      if (l) begin
        e.dout = acc_m[i][31:0];
        e.ovf  = ovf_m[i];
        e.t    = en_cnt + ns_p[i] + 1;
        sb[i].push_back(e);
      end
    end
  endtask

  task automatic term(input logic [15:0] a, input logic [15:0] b, input logic f, input logic l);
    in_valid = 1'b1;
    din0     = a;
    din1     = b;
    first    = f;
    last     = l;
    c_last   = cyc;
    if (ce) model_term(a, b, f, l);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    first    = 1'b0;
    last     = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_out_valid[%0d]", i), {31'd0, ov_w[i]}, 32'd0);
      chk($sformatf("rst_dout[%0d]", i), dout_w[i], 32'd0);
      chk($sformatf("rst_overflow[%0d]", i), {31'd0, ovf_w[i]}, 32'd0);
      acc_m[i] = 0;
      ovf_m[i] = 1'b0;
      sb[i].delete();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every pulse must match the head entry on time.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (ov_w[i] === 1'b1) begin
        n_assert++;
        assert (sb[i].size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_pulse[%0d] observed=%h expected=none", i, dout_w[i]);
        end
        if (sb[i].size() > 0) begin
          e = sb[i].pop_front();
          pulse_cyc[i] = cyc;
          chk($sformatf("latency[%0d]", i), en_cnt, e.t);
          chk($sformatf("dout[%0d]", i), dout_w[i], e.dout);
          chk($sformatf("overflow[%0d]", i), {31'd0, ovf_w[i]}, {31'd0, e.ovf});
        end
      end else if (sb[i].size() > 0 && rst_n) begin
        n_assert++;
        assert (sb[i][0].t >= en_cnt) else begin
          n_fail++;
          $error("FAIL missing_pulse[%0d] observed=none expected=%h at en_cnt %0d", i, sb[i][0].dout, sb[i][0].t);
        end
        if (sb[i][0].t < en_cnt) void'(sb[i].pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) pulse_cyc[i] = -1;
    @(posedge clk);
    #1;
    do_reset();

    // Single term, first=last
    term(16'hFFFD, 16'hFFFF, 1'b1, 1'b1);
    idle(8);
    chk("single_dout0", dout_w[0], 32'hFFFD0003);
    chk("single_ovf0", {31'd0, ovf_w[0]}, 32'd0);
    chk("single_lat0", pulse_cyc[0], c_last + 4);
    chk("single_dout2", dout_w[2], 32'd3);

    // Back-to-back sums: last followed immediately by first
    term(16'd100, 16'd200, 1'b1, 1'b0);
    term(16'd100, 16'd200, 1'b0, 1'b0);
    term(16'd100, 16'd200, 1'b0, 1'b0);
    term(16'd100, 16'd200, 1'b0, 1'b1);
    term(16'd7, 16'd9, 1'b1, 1'b1);
    idle(8);
    chk("b2b_dout0", dout_w[0], 32'd63);

    // Negative overflow: saturate vs wrap
    term(16'h8000, 16'hFFFF, 1'b1, 1'b0);
    term(16'h8000, 16'hFFFF, 1'b0, 1'b1);
    idle(8);
    chk("negsat_dout0", dout_w[0], 32'h80000000);
    chk("negsat_ovf0", {31'd0, ovf_w[0]}, 32'd1);
    chk("negwrap_dout1", dout_w[1], 32'h00010000);
    chk("negwrap_ovf1", {31'd0, ovf_w[1]}, 32'd1);

    // Positive overflow then a further add: sticky flag, re-clamp
    term(16'h7FFF, 16'hFFFF, 1'b1, 1'b0);
    term(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
    term(16'd1, 16'd1, 1'b0, 1'b1);
    idle(8);
    chk("possat_dout0", dout_w[0], 32'h7FFFFFFF);
    chk("possat_ovf0", {31'd0, ovf_w[0]}, 32'd1);
    chk("poswrap_dout1", dout_w[1], 32'hFFFD0003);
    chk("poswrap_ovf1", {31'd0, ovf_w[1]}, 32'd1);

    // Signed din1
    term(16'hFFFE, 16'hFFFF, 1'b1, 1'b1);
    idle(8);
    chk("signed_dout2", dout_w[2], 32'd2);
    chk("unsigned_dout0", dout_w[0], 32'hFFFE0002);

    // ce held low 5 cycles while the last term is in flight
    term(16'd1, 16'd1, 1'b1, 1'b0);
    term(16'd1, 16'd1, 1'b0, 1'b0);
    term(16'd1, 16'd1, 1'b0, 1'b1);
    ce       = 1'b0;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ce = 1'b1;
    idle(8);
    chk("stall_dout0", dout_w[0], 32'd3);
    chk("stall_lat0", pulse_cyc[0], c_last + 4 + 5);
    chk("stall_lat3", pulse_cyc[3], c_last + 2 + 5);

    // Reset mid-sum discards it; acc restarts from zero for a non-first term
    term(16'd2, 16'd3, 1'b1, 1'b0);
    term(16'd2, 16'd3, 1'b0, 1'b0);
    do_reset();
    term(16'd5, 16'd5, 1'b0, 1'b1);
    idle(8);
    chk("postrst_dout3", dout_w[3], 32'd25);
    chk("postrst_lat3", pulse_cyc[3], c_last + 2);
    chk("postrst_dout0", dout_w[0], 32'd25);

    idle(4);
    for (int i = 0; i < 4; i++) chk($sformatf("drained[%0d]", i), sb[i].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_mac_pipe.md
CONV_MAC_PIPE -- requirements
Module: conv_mac_pipe

Interface
REQ-001 SHALL have parameter ID, default 1: instance tag, no functional effect.
REQ-002 SHALL have parameter DIN0_WIDTH, default 16: width of signed operand din0.
REQ-003 SHALL have parameter DIN1_WIDTH, default 16: width of operand din1.
REQ-004 SHALL have parameter DOUT_WIDTH, default 32: accumulator/result width; legal only if DOUT_WIDTH >= DIN0_WIDTH+DIN1_WIDTH.
REQ-005 SHALL have parameter NUM_STAGE, default 3: multiplier pipeline depth; legal range 1..4.
REQ-006 SHALL have parameter DIN1_SIGNED, default 0: 0 = din1 unsigned (zero-extended), 1 = din1 signed.
REQ-007 SHALL have parameter SATURATE, default 1: 1 = clamp accumulator on overflow, 0 = wrap modulo 2^DOUT_WIDTH.
REQ-008 SHALL have port ap_clk, input, 1: single clock, rising edge.
REQ-009 SHALL have port ap_rst_n, input, 1: asynchronous, active-low reset.
REQ-010 SHALL have port ce, input, 1: clock enable; low freezes every register.
REQ-011 SHALL have port in_valid, input, 1: din0/din1/first/last valid this cycle.
REQ-012 SHALL have port din0, input, DIN0_WIDTH: signed multiplicand.
REQ-013 SHALL have port din1, input, DIN1_WIDTH: multiplier, signedness per DIN1_SIGNED.
REQ-014 SHALL have port first, input, 1: term starts a new sum.
REQ-015 SHALL have port last, input, 1: term ends the current sum.
REQ-016 SHALL have port out_valid, output, 1: one-cycle pulse, dout holds a completed sum.
REQ-017 SHALL have port dout, output, DOUT_WIDTH: signed completed sum.
REQ-018 SHALL have port overflow, output, 1: the sum on dout saturated/wrapped at least once.

Function
REQ-019 SHALL form product = signed(din0) * (DIN1_SIGNED ? signed(din1) : {1'b0,din1}), exact, sign-extended to DOUT_WIDTH.
REQ-020 SHALL carry product, valid, first and last through NUM_STAGE register stages, advancing only when ce=1.
REQ-021 SHALL, at the accumulate stage when the emerging term is valid: acc <= product if first=1, else acc <= acc + product.
REQ-022 SHALL leave acc unchanged on bubbles (emerging valid=0).
REQ-023 SHALL compute the sum in DOUT_WIDTH+1 bits; overflow when the result falls outside the signed DOUT_WIDTH range.
REQ-024 SHALL, with SATURATE=1, clamp on overflow to 2^(DOUT_WIDTH-1)-1 (positive) or -2^(DOUT_WIDTH-1) (negative); with SATURATE=0, keep the low DOUT_WIDTH bits.
REQ-025 SHALL keep a sticky overflow bit per sum: cleared/loaded by a first term (a first term never overflows), set by any overflowing add.
REQ-026 SHALL, when the emerging valid term has last=1, load dout and overflow with the final sum and flag and assert out_valid on the next ce=1 edge.
REQ-027 SHALL give latency NUM_STAGE+1 ce=1 cycles from in_valid&last sampled to out_valid high.
REQ-028 SHALL treat first=1 and last=1 on the same term as a one-term sum: dout = product.
REQ-029 SHALL accept a last term followed on the next cycle by a first term without a bubble or lost output; throughput is one term per ce=1 cycle.
REQ-030 SHALL hold out_valid low when ce=0 and extend no pulse; dout and overflow hold until the next out_valid.
REQ-031 SHALL treat a non-first term arriving with no open sum (after reset or after last) as accumulating onto acc (zero after reset); the source is responsible for framing.

Reset
REQ-032 SHALL, on ap_rst_n=0, immediately clear all pipeline valids, acc, dout, overflow and out_valid to 0, independent of ap_clk and ce.
REQ-033 SHALL discard any partial sum or in-flight term on reset; no out_valid for it after release.
REQ-034 SHALL accept a new term on the first ap_clk edge with ap_rst_n=1.

Verification
REQ-035 SHALL cover: defaults, ce=1, din0=-3, din1=65535, first=last=1 -> exactly 4 cycles later out_valid=1 for 1 cycle, dout=-196605, overflow=0.
REQ-036 SHALL cover: 4 back-to-back terms din0=100, din1=200 (first on 1st, last on 4th), then immediately 1 term 7x9 first=last -> dout=80000, then next cycle dout=63.
REQ-037 SHALL cover: SATURATE=1, two terms din0=-32768, din1=65535 -> dout=0x80000000, overflow=1; same with SATURATE=0 -> dout=0x00010000 (wrapped), overflow=1.
REQ-038 SHALL cover: DIN1_SIGNED=1, din0=-2, din1=16'hFFFF (-1), single term -> dout=2.
REQ-039 SHALL cover: ce held low 5 cycles mid-sum of 3 terms 1x1 -> out_valid delayed exactly 5 cycles, dout=3, no duplicate pulse.
REQ-040 SHALL cover: ap_rst_n pulsed low between term 2 and last of a sum, NUM_STAGE=1 -> no out_valid for that sum; next single term 5x5 -> dout=25 after 2 cycles.
